cond_logic_unit: RTL and testbench
==================================

Name: cond_logic_unit

Overview:
- Condition-check stage directly downstream of the ALU decoder in the single-cycle ARM-subset datapath.
- Holds the architectural NZCV flag register; updates it per FlagW when the instruction executes.
- Evaluates the 4-bit Cond field against the current flags and gates PCS/RegW/MemW into the final write enables.
- NoWrite from the decoder suppresses register writeback for CMP.

Parameters:
- CNT_W, 16, width of the optional executed/squashed instruction counters (valid range 4..32)

Ports:
- clk  input  1  single system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- Stall  input  1  1 = hold all state; suppress PCSrc/RegWrite/MemWrite/flag update
- Cond  input  4  instruction condition field, Instr[31:28]
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  input  2  from ALU decoder; [1] enables N,Z write, [0] enables C,V write
- NoWrite  input  1  from ALU decoder; 1 = suppress register write (CMP)
- PCS  input  1  main-decoder PC-write request
- RegW  input  1  main-decoder register-write request
- MemW  input  1  main-decoder memory-write request
- PCSrc  output  1  gated PC select
- RegWrite  output  1  gated register write enable
- MemWrite  output  1  gated memory write enable
- CondEx  output  1  1 = current instruction executes
- Flags  output  4  registered {N,Z,C,V}
- ExecCount  output  CNT_W  instructions executed (only with COND_STATS_EN)
- SquashCount  output  CNT_W  instructions squashed by condition (only with COND_STATS_EN)

Behaviour:
- Reset (reset_n low, async): Flags=4'b0000; counters=0. Outputs follow the combinational equations below using cleared flags. Deassertion is sampled on the next rising edge.
- Flag register: two independently enabled 2-bit halves, NZ=Flags[3:2] and CV=Flags[1:0].
  - NZ loads ALUFlags[3:2] on a rising edge iff FlagW[1] & CondEx & ~Stall.
  - CV loads ALUFlags[1:0] under the same rule using FlagW[0].
  - Otherwise each half holds.
- Condition evaluation is combinational on the registered Flags, not on ALUFlags; flags written by an instruction affect only later instructions.
- CondEx by Cond:
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C
  - 0100 N; 0101 ~N; 0110 V; 0111 ~V
  - 1000 C&~Z; 1001 ~C|Z
  - 1010 N==V; 1011 N!=V
  - 1100 ~Z&(N==V); 1101 Z|(N!=V)
  - 1110 1 (AL); 1111 0 (reserved, squashed)
- Gated outputs, zero latency (combinational):
  - PCSrc = PCS & CondEx & ~Stall
  - RegWrite = RegW & CondEx & ~NoWrite & ~Stall
  - MemWrite = MemW & CondEx & ~Stall
- Stall=1: no state change at the clock edge; CondEx still reflects the evaluation.
- Simultaneous FlagW=2'b11 with CondEx=0: no flag change.
- reset_n asserted mid-cycle clears Flags immediately, and CondEx re-evaluates against 0000.

Optional Feature:
- Macro: COND_STATS_EN.
- Defined: on each rising edge with ~Stall and reset_n high:
  - ExecCount increments when CondEx=1.
  - SquashCount increments when CondEx=0.
  - Both saturate at all-ones; they do not wrap.
- Not defined: both outputs tied to 0, no counter flops.

Test Plan:
- Reset with reset_n=0 mid-cycle, Flags previously 4'b1111 -> Flags=0000 immediately; Cond=0000 (EQ) gives CondEx=0 and PCSrc=0 with PCS=1.
- Cond=1110, ALUFlags=0110, FlagW=11, RegW=1, NoWrite=0 -> RegWrite=1 same cycle; Flags=0110 after the edge; next Cond=0000 gives CondEx=1.
- Flags=0110, Cond=0001 (NE), FlagW=11, ALUFlags=1000 -> CondEx=0, RegWrite=0, MemWrite=0; Flags stay 0110 after the edge.
- FlagW=10, ALUFlags=1011 from Flags=0110, Cond=1110 -> Flags=1010; then Cond=1010 (GE) gives CondEx=0 and Cond=1011 (LT) gives CondEx=1.
- CMP: Cond=1110, RegW=1, NoWrite=1, FlagW=11 -> RegWrite=0, flags updated; Stall=1 on the same inputs leaves Flags unchanged and all gated outputs 0.
- With COND_STATS_EN and CNT_W=4: 20 edges with Cond=1110 -> ExecCount saturates at 15; 3 edges with Cond=1111 -> SquashCount=3.

Source files
------------

// File: rtl/cond_logic_unit.sv
// cond_logic_unit: condition-check stage for the single-cycle ARM-subset datapath.
// It holds the NZCV flag register and evaluates the instruction condition field
// against the registered flags. The PC-select, register-write and memory-write
// requests from the decoder only take effect when the condition passes.
// Optional build macro COND_STATS_EN adds saturating counters for executed and
// squashed instructions. When it is undefined, both counter outputs are
// constant zero and no counter flops exist.
module cond_logic_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Stall,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             NoWrite,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    // Evaluate a condition code against {N,Z,C,V}; 1111 is reserved and never executes.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       nz_en;
    logic       cv_en;

    assign Flags = {nz_q, cv_q};

    // Condition check and write-enable gating; the flags used here are the registered ones.
    always_comb begin
        CondEx   = cond_eval(Cond, Flags);
        PCSrc    = PCS  & CondEx & ~Stall;
        RegWrite = RegW & CondEx & ~NoWrite & ~Stall;
        MemWrite = MemW & CondEx & ~Stall;
        nz_en    = FlagW[1] & CondEx & ~Stall;
        cv_en    = FlagW[0] & CondEx & ~Stall;
    end

    // Flag register: the NZ and CV halves load independently and only for executing, unstalled instructions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            if (nz_en) nz_q <= ALUFlags[3:2];
            if (cv_en) cv_q <= ALUFlags[1:0];
        end
    end

`ifdef COND_STATS_EN
    // Saturating increment: the counter stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] squash_q;

    // Statistics: every unstalled cycle is counted as either executed or squashed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (!Stall) begin
            if (CondEx) exec_q   <= sat_inc(exec_q);
            else        squash_q <= sat_inc(squash_q);
        end
    end

    assign ExecCount   = exec_q;
    assign SquashCount = squash_q;
`else
    assign ExecCount   = '0;
    assign SquashCount = '0;
`endif

endmodule

// File: tb/tb_cond_logic_unit.sv
// Testbench for cond_logic_unit. It applies a vector table over all condition
// codes plus hand sequences for flag updates, CMP, stall and reset. Expected
// gated outputs are queued when the stimulus is driven and are compared when
// the outputs are sampled.
module tb_cond_logic_unit;

    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic          Stall;
    logic [3:0]    Cond;
    logic [3:0]    ALUFlags;
    logic [1:0]    FlagW;
    logic          NoWrite;
    logic          PCS;
    logic          RegW;
    logic          MemW;
    logic          PCSrc;
    logic          RegWrite;
    logic          MemWrite;
    logic          CondEx;
    logic [3:0]    Flags;
    logic [CW-1:0] ExecCount;
    logic [CW-1:0] SquashCount;

    cond_logic_unit #(.CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .Stall(Stall), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .NoWrite(NoWrite), .PCS(PCS),
        .RegW(RegW), .MemW(MemW), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
        .ExecCount(ExecCount), .SquashCount(SquashCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags to preload, cond, ctl={PCS,RegW,MemW,NoWrite}, expected CondEx
    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic [3:0] ctl;
        logic       ce;
    } vec_t;

    vec_t       vecs[25];
    logic [3:0] sb_q[$];
    int         total;
    int         bad;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push the expected {CondEx,PCSrc,RegWrite,MemWrite}.
    task automatic expect_out(input logic [3:0] e);
        sb_q.push_back(e);
    endtask

    // Pop and compare against the current outputs.
    task automatic sample_out(input string name);
        logic [3:0] e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty got %0h expected entry", name,
                     {CondEx, PCSrc, RegWrite, MemWrite});
        end else begin
            e = sb_q.pop_front();
            check(name, {12'd0, CondEx, PCSrc, RegWrite, MemWrite}, {12'd0, e});
        end
    endtask

    task automatic idle_inputs();
        Stall = 0; Cond = 4'b1110; ALUFlags = 0; FlagW = 0;
        NoWrite = 0; PCS = 0; RegW = 0; MemW = 0;
    endtask

    // Load the flag register through an always-executing instruction.
    task automatic load_flags(input logic [3:0] f);
        @(negedge clk);
        idle_inputs();
        FlagW = 2'b11;
        ALUFlags = f;
        @(posedge clk);
        #1;
        FlagW = 2'b00;
        check("load_flags", {12'd0, Flags}, {12'd0, f});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        vecs[0]  = '{4'b0100, 4'b0000, 4'b1110, 1'b1};
        vecs[1]  = '{4'b0000, 4'b0000, 4'b1110, 1'b0};
        vecs[2]  = '{4'b0100, 4'b0001, 4'b1010, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0001, 4'b0101, 1'b1};
        vecs[4]  = '{4'b0010, 4'b0010, 4'b1100, 1'b1};
        vecs[5]  = '{4'b0000, 4'b0010, 4'b1110, 1'b0};
        vecs[6]  = '{4'b0010, 4'b0011, 4'b1110, 1'b0};
        vecs[7]  = '{4'b1000, 4'b0100, 4'b0110, 1'b1};
        vecs[8]  = '{4'b0000, 4'b0101, 4'b1000, 1'b1};
        vecs[9]  = '{4'b0001, 4'b0110, 4'b0100, 1'b1};
        vecs[10] = '{4'b0001, 4'b0111, 4'b1110, 1'b0};
        vecs[11] = '{4'b0010, 4'b1000, 4'b0010, 1'b1};
        vecs[12] = '{4'b0110, 4'b1000, 4'b1110, 1'b0};
        vecs[13] = '{4'b0110, 4'b1001, 4'b1110, 1'b1};
        vecs[14] = '{4'b0010, 4'b1001, 4'b1110, 1'b0};
        vecs[15] = '{4'b1001, 4'b1010, 4'b1110, 1'b1};
        vecs[16] = '{4'b1000, 4'b1010, 4'b1110, 1'b0};
        vecs[17] = '{4'b1000, 4'b1011, 4'b1111, 1'b1};
        vecs[18] = '{4'b0000, 4'b1100, 4'b1110, 1'b1};
        vecs[19] = '{4'b0100, 4'b1100, 4'b1110, 1'b0};
        vecs[20] = '{4'b1001, 4'b1100, 4'b0100, 1'b1};
        vecs[21] = '{4'b0001, 4'b1101, 4'b1110, 1'b1};
        vecs[22] = '{4'b0000, 4'b1101, 4'b1110, 1'b0};
        vecs[23] = '{4'b1111, 4'b1110, 4'b1110, 1'b1};
        vecs[24] = '{4'b1111, 4'b1111, 4'b1110, 1'b0};

        reset_n = 0;
        idle_inputs();
        Cond = 4'b0000;
        PCS = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {12'd0, Flags}, 16'h0000);
        expect_out(4'b0000);
        sample_out("reset_eq");
        @(negedge clk);
        reset_n = 1;

        // Table-driven sweep of all condition codes.
        for (int i = 0; i < 25; i++) begin
            load_flags(vecs[i].flags);
            @(negedge clk);
            Cond = vecs[i].cond;
            {PCS, RegW, MemW, NoWrite} = vecs[i].ctl;
            expect_out({vecs[i].ce, vecs[i].ctl[3] & vecs[i].ce,
                        vecs[i].ctl[2] & vecs[i].ce & ~vecs[i].ctl[0],
                        vecs[i].ctl[1] & vecs[i].ce});
            #1;
            sample_out($sformatf("vec%0d", i));
        end

        // Asynchronous reset in mid-cycle clears 1111 at once.
        load_flags(4'b1111);
        @(negedge clk);
        Cond = 4'b0000;
        PCS = 1;
        #2;
        reset_n = 0;
        #1;
        check("async_reset_flags", {12'd0, Flags}, 16'h0000);
        expect_out(4'b0000);
        sample_out("async_reset_eq");
        @(negedge clk);
        reset_n = 1;

        // An AL instruction writes the flags; the new flags are used from the next cycle.
        @(negedge clk);
        idle_inputs();
        Cond = 4'b1110; ALUFlags = 4'b0110; FlagW = 2'b11; RegW = 1;
        expect_out(4'b1010);
        #1;
        sample_out("al_regwrite");
        @(posedge clk);
        #1;
        check("al_flags", {12'd0, Flags}, 16'h0006);
        @(negedge clk);
        idle_inputs();
        Cond = 4'b0000;
        expect_out(4'b1000);
        #1;
        sample_out("eq_after_al");

        // A failing NE does not write the flags.
        @(negedge clk);
        Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b1000; RegW = 1; MemW = 1;
        expect_out(4'b0000);
        #1;
        sample_out("ne_squash");
        @(posedge clk);
        #1;
        check("ne_flags_hold", {12'd0, Flags}, 16'h0006);

        // A write with only NZ enabled; CV keeps its old value.
        @(negedge clk);
        idle_inputs();
        Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1011;
        @(posedge clk);
        #1;
        check("nz_only_flags", {12'd0, Flags}, 16'h000a);
        @(negedge clk);
        idle_inputs();
        Cond = 4'b1010;
        expect_out(4'b0000);
        #1;
        sample_out("ge_false");
        Cond = 4'b1011;
        expect_out(4'b1000);
        #1;
        sample_out("lt_true");

        // A write with only CV enabled.
        @(negedge clk);
        idle_inputs();
        FlagW = 2'b01; ALUFlags = 4'b0101;
        @(posedge clk);
        #1;
        check("cv_only_flags", {12'd0, Flags}, 16'h0009);

        // CMP, then a stall with the same inputs.
        @(negedge clk);
        idle_inputs();
        Cond = 4'b1110; RegW = 1; NoWrite = 1; FlagW = 2'b11; ALUFlags = 4'b0110;
        expect_out(4'b1000);
        #1;
        sample_out("cmp_no_regwrite");
        @(posedge clk);
        #1;
        check("cmp_flags", {12'd0, Flags}, 16'h0006);
        @(negedge clk);
        Stall = 1; PCS = 1; MemW = 1; NoWrite = 0; ALUFlags = 4'b1001;
        expect_out(4'b1000);
        #1;
        sample_out("stall_gates");
        @(posedge clk);
        #1;
        check("stall_flags_hold", {12'd0, Flags}, 16'h0006);

        // Counters: 20 executed edges, then 3 squashed edges.
        do_reset();
        @(negedge clk);
        idle_inputs();
        Cond = 4'b1110;
        repeat (20) @(posedge clk);
        #1;
`ifdef COND_STATS_EN
        check("exec_sat", {12'd0, ExecCount}, 16'd15);
`else
        check("exec_off", {12'd0, ExecCount}, 16'd0);
`endif
        @(negedge clk);
        Cond = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        Stall = 1;
`ifdef COND_STATS_EN
        check("squash_cnt", {12'd0, SquashCount}, 16'd3);
        check("exec_held", {12'd0, ExecCount}, 16'd15);
`else
        check("squash_off", {12'd0, SquashCount}, 16'd0);
`endif
        @(posedge clk);
        #1;
`ifdef COND_STATS_EN
        check("squash_stall_hold", {12'd0, SquashCount}, 16'd3);
`else
        check("squash_off_stall", {12'd0, SquashCount}, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
